// File: rtl/edge_binarize_pkg.sv
// Shared types, constants and saturation helper for the edge_binarize stage.
package edge_binarize_pkg;

   localparam int CNT_W_DEF  = 11;
   localparam int SUM_W_DEF  = 32;
   localparam int THR_MATH_W = 10;
   localparam int SAT_IN_W   = 40;

   localparam logic [23:0] EDGE_ON  = 24'hFF_FFFF;
   localparam logic [23:0] EDGE_OFF = 24'h00_0000;

   typedef struct packed {
      logic [7:0] pix;
      logic       border;
      logic       last;
      logic [7:0] thr;
   } s1_t;

   localparam s1_t S1_RST = '{pix: 8'h00, border: 1'b0, last: 1'b0, thr: 8'h00};

   function automatic logic [7:0] sat8(input logic [SAT_IN_W-1:0] v);
      logic [7:0] r;
      if (v > {{(SAT_IN_W-8){1'b0}}, 8'hFF}) begin
         r = 8'hFF;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_binarize_thr_calc.sv
// Adaptive threshold arithmetic: frame mean from the running sum, then
// mean * 1.5 + offset, all saturated to 8 bits. Purely combinational.
module edge_thr_calc
   import edge_binarize_pkg::*;
#(
   parameter int SUM_W      = SUM_W_DEF,
   parameter int MEAN_SHIFT = 21
) (
   input  logic [SUM_W-1:0] sum,
   input  logic [7:0]       pix,
   input  logic             last,
   input  logic [7:0]       offset,
   output logic [7:0]       mean,
   output logic [7:0]       thr_next
);

   logic [SUM_W:0]          total_s;
   logic [SUM_W:0]          shifted_s;
   logic [THR_MATH_W-1:0]   thr_wide_s;

   // The final pixel of the frame is folded into the sum before averaging.
   always_comb begin
      total_s = {1'b0, sum};
      if (last) begin
         total_s = {1'b0, sum} + {{(SUM_W-7){1'b0}}, pix};
      end else begin
         total_s = {1'b0, sum};
      end
      shifted_s  = total_s >> MEAN_SHIFT;
      mean       = sat8({{(SAT_IN_W-SUM_W-1){1'b0}}, shifted_s});
      thr_wide_s = {2'b00, mean} + {3'b000, mean[7:1]} + {2'b00, offset};
      thr_next   = sat8({{(SAT_IN_W-THR_MATH_W){1'b0}}, thr_wide_s});
   end

endmodule

// File: rtl/edge_binarize.sv
// Gradient-magnitude thresholding to a binary edge map with border zeroing and
// a manual or adaptive threshold. Optional stats ports: EDGE_BINARIZE_STATS_EN.
module edge_binarize
   import edge_binarize_pkg::*;
#(
   parameter int WIDTH      = 1920,
   parameter int HEIGHT     = 1080,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int SUM_W      = SUM_W_DEF,
   parameter int MEAN_SHIFT = 21,
   parameter int INIT_THR   = 64,
   parameter int THR_OFFSET = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        src_valid,
   input  logic [23:0] src_data,
   input  logic        manual_en,
   input  logic [7:0]  manual_thr,
   output logic        dst_valid,
   output logic [23:0] dst_data,
   output logic        frame_done,
   output logic [7:0]  thr_active
`ifdef EDGE_BINARIZE_STATS_EN
   ,
   output logic [21:0] edge_count,
   output logic [7:0]  frame_mean
`endif
);

   localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HEIGHT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]       THR_RST  = 8'(INIT_THR);
   localparam logic [7:0]       OFFSET   = 8'(THR_OFFSET);

   logic [CNT_W-1:0] cnt_w_q, cnt_w_d;
   logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [7:0]       adapt_thr_q, adapt_thr_d;
   logic             cfg_en_q, cfg_en_d;
   logic [7:0]       cfg_thr_q, cfg_thr_d;
   logic [7:0]       thr_active_q, thr_active_d;
   logic             s1_valid_q, s1_valid_d;
   s1_t              s1_q, s1_d;
   logic             dst_valid_q, dst_valid_d;
   logic [23:0]      dst_data_q, dst_data_d;
   logic             frame_done_q, frame_done_d;

   logic [7:0]       pix_s;
   logic             start_s;
   logic             last_s;
   logic             border_s;
   logic [7:0]       thr_sel_s;
   logic             edge_s;
   logic [7:0]       mean_s;
   logic [7:0]       thr_next_s;
   logic             unused_s;

   // Position decode for the pixel presented this cycle.
   always_comb begin
      pix_s    = src_data[7:0];
      start_s  = src_valid && (cnt_w_q == CNT_ZERO) && (cnt_h_q == CNT_ZERO);
      last_s   = (cnt_w_q == W_LAST) && (cnt_h_q == H_LAST);
      border_s = (cnt_h_q == CNT_ZERO) || (cnt_h_q == H_LAST) ||
                 (cnt_w_q == CNT_ZERO) || (cnt_w_q == W_LAST);
   end

   // Raster position counters, advanced only by accepted pixels.
   always_comb begin
      cnt_w_d = cnt_w_q;
      cnt_h_d = cnt_h_q;
      if (src_valid) begin
         if (cnt_w_q == W_LAST) begin
            cnt_w_d = CNT_ZERO;
            if (cnt_h_q == H_LAST) begin
               cnt_h_d = CNT_ZERO;
            end else begin
               cnt_h_d = cnt_h_q + CNT_ONE;
            end
         end else begin
            cnt_w_d = cnt_w_q + CNT_ONE;
         end
      end else begin
         cnt_w_d = cnt_w_q;
         cnt_h_d = cnt_h_q;
      end
   end

   // On the first pixel the fresh configuration is used directly, since the
   // latched copy only becomes visible one cycle later.
   always_comb begin
      thr_sel_s = adapt_thr_q;
      if (start_s) begin
         if (manual_en) begin
            thr_sel_s = manual_thr;
         end else begin
            thr_sel_s = adapt_thr_q;
         end
      end else if (cfg_en_q) begin
         thr_sel_s = cfg_thr_q;
      end else begin
         thr_sel_s = adapt_thr_q;
      end
   end

   // Frame configuration latch and displayed threshold.
   always_comb begin
      cfg_en_d     = cfg_en_q;
      cfg_thr_d    = cfg_thr_q;
      thr_active_d = thr_active_q;
      if (start_s) begin
         cfg_en_d     = manual_en;
         cfg_thr_d    = manual_thr;
         thr_active_d = thr_sel_s;
      end else begin
         cfg_en_d     = cfg_en_q;
         cfg_thr_d    = cfg_thr_q;
         thr_active_d = thr_active_q;
      end
   end

   edge_thr_calc #(
      .SUM_W      (SUM_W),
      .MEAN_SHIFT (MEAN_SHIFT)
   ) u_thr_calc (
      .sum      (sum_q),
      .pix      (pix_s),
      .last     (last_s),
      .offset   (OFFSET),
      .mean     (mean_s),
      .thr_next (thr_next_s)
   );

   // Frame sum accumulation and adaptive threshold update on the last pixel.
   always_comb begin
      sum_d       = sum_q;
      adapt_thr_d = adapt_thr_q;
      if (src_valid) begin
         if (last_s) begin
            sum_d       = {SUM_W{1'b0}};
            adapt_thr_d = thr_next_s;
         end else begin
            sum_d       = sum_q + {{(SUM_W-8){1'b0}}, pix_s};
            adapt_thr_d = adapt_thr_q;
         end
      end else begin
         sum_d       = sum_q;
         adapt_thr_d = adapt_thr_q;
      end
   end

   // Two-stage pixel pipeline: stage 1 captures the decision inputs, stage 2
   // produces the binarized output.
   always_comb begin
      s1_valid_d = src_valid;
      s1_d       = s1_q;
      if (src_valid) begin
         s1_d.pix    = pix_s;
         s1_d.border = border_s;
         s1_d.last   = last_s;
         s1_d.thr    = thr_sel_s;
      end else begin
         s1_d = s1_q;
      end
      edge_s       = (s1_q.pix > s1_q.thr) && !s1_q.border;
      dst_valid_d  = s1_valid_q;
      frame_done_d = s1_valid_q && s1_q.last;
      if (s1_valid_q) begin
         dst_data_d = edge_s ? EDGE_ON : EDGE_OFF;
      end else begin
         dst_data_d = dst_data_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_w_q      <= CNT_ZERO;
         cnt_h_q      <= CNT_ZERO;
         sum_q        <= {SUM_W{1'b0}};
         adapt_thr_q  <= THR_RST;
         cfg_en_q     <= 1'b0;
         cfg_thr_q    <= 8'h00;
         thr_active_q <= THR_RST;
         s1_valid_q   <= 1'b0;
         s1_q         <= S1_RST;
         dst_valid_q  <= 1'b0;
         dst_data_q   <= EDGE_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_w_q      <= cnt_w_d;
         cnt_h_q      <= cnt_h_d;
         sum_q        <= sum_d;
         adapt_thr_q  <= adapt_thr_d;
         cfg_en_q     <= cfg_en_d;
         cfg_thr_q    <= cfg_thr_d;
         thr_active_q <= thr_active_d;
         s1_valid_q   <= s1_valid_d;
         s1_q         <= s1_d;
         dst_valid_q  <= dst_valid_d;
         dst_data_q   <= dst_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dst_valid  = dst_valid_q;
   assign dst_data   = dst_data_q;
   assign frame_done = frame_done_q;
   assign thr_active = thr_active_q;

`ifdef EDGE_BINARIZE_STATS_EN
   logic [21:0] edge_acc_q, edge_acc_d;
   logic [21:0] edge_count_q, edge_count_d;
   logic [7:0]  s1_mean_q, s1_mean_d;
   logic [7:0]  frame_mean_q, frame_mean_d;

   // Edge tally and mean, published in the same cycle as frame_done.
   always_comb begin
      edge_acc_d   = edge_acc_q;
      edge_count_d = edge_count_q;
      frame_mean_d = frame_mean_q;
      s1_mean_d    = s1_mean_q;
      if (src_valid && last_s) begin
         s1_mean_d = mean_s;
      end else begin
         s1_mean_d = s1_mean_q;
      end
      if (s1_valid_q) begin
         if (s1_q.last) begin
            edge_count_d = edge_acc_q + {21'h0, edge_s};
            edge_acc_d   = 22'h0;
            frame_mean_d = s1_mean_q;
         end else begin
            edge_acc_d = edge_acc_q + {21'h0, edge_s};
         end
      end else begin
         edge_acc_d = edge_acc_q;
      end
   end

   // Stats registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_acc_q   <= 22'h0;
         edge_count_q <= 22'h0;
         s1_mean_q    <= 8'h00;
         frame_mean_q <= 8'h00;
      end else begin
         edge_acc_q   <= edge_acc_d;
         edge_count_q <= edge_count_d;
         s1_mean_q    <= s1_mean_d;
         frame_mean_q <= frame_mean_d;
      end
   end

   assign edge_count = edge_count_q;
   assign frame_mean = frame_mean_q;
   assign unused_s   = ^src_data[23:8];
`else
   assign unused_s   = ^{src_data[23:8], mean_s};
`endif

endmodule

// File: tb/tb_edge_binarize.sv
// Directed bench for edge_binarize on an 8x4 frame with MEAN_SHIFT=5.
module tb_edge_binarize;

   localparam logic [23:0] ON  = 24'hFF_FFFF;
   localparam logic [23:0] OFF = 24'h00_0000;

   logic        clk;
   logic        rst_n;
   logic        src_valid;
   logic [23:0] src_data;
   logic        manual_en;
   logic [7:0]  manual_thr;
   logic        dst_valid;
   logic [23:0] dst_data;
   logic        frame_done;
   logic [7:0]  thr_active;
`ifdef EDGE_BINARIZE_STATS_EN
   logic [21:0] edge_count;
   logic [7:0]  frame_mean;
`endif

   int total = 0;
   int bad   = 0;
   int stray_fd = 0;

   logic [23:0] out_q[$];
   logic        fd_q[$];
   logic [7:0]  fpx[0:31];
   logic [23:0] exp_seq[0:63];
   logic [7:0]  thr_a, thr_b;

   edge_binarize #(
      .WIDTH(8), .HEIGHT(4), .CNT_W(11), .SUM_W(32),
      .MEAN_SHIFT(5), .INIT_THR(64), .THR_OFFSET(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .manual_en  (manual_en),
      .manual_thr (manual_thr),
      .dst_valid  (dst_valid),
      .dst_data   (dst_data),
      .frame_done (frame_done),
      .thr_active (thr_active)
`ifdef EDGE_BINARIZE_STATS_EN
      ,
      .edge_count (edge_count),
      .frame_mean (frame_mean)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (dst_valid === 1'b1) begin
         out_q.push_back(dst_data);
         fd_q.push_back(frame_done);
      end else if (frame_done === 1'b1) begin
         stray_fd++;
      end
   end

   task automatic drive_pix(input logic [7:0] p);
      @(negedge clk);
      src_valid = 1'b1;
      src_data  = {p, p, p};
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         src_valid = 1'b0;
         src_data  = 24'h0;
      end
   endtask

   task automatic send_frame(input int gap_max, output logic [7:0] thr_at_start);
      thr_at_start = 8'h00;
      for (int i = 0; i < 32; i++) begin
         if (gap_max > 0) drive_idle(int'($urandom_range(0, gap_max)));
         @(negedge clk);
         if (i == 1) thr_at_start = thr_active;
         src_valid = 1'b1;
         src_data  = {fpx[i], fpx[i], fpx[i]};
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 32; i++) fpx[i] = v;
   endtask

   task automatic clear_mon();
      out_q.delete();
      fd_q.delete();
   endtask

   function automatic int count_on(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (out_q[i] === ON) n++;
      return n;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; src_valid = 1'b0; src_data = 24'h0;
      manual_en = 1'b0; manual_thr = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (dst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", dst_valid); end
      total++; if (dst_data !== OFF) begin bad++; $display("FAIL rst_data got=%h want=%h", dst_data, OFF); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd got=%b want=0", frame_done); end
      total++; if (thr_active !== 8'd64) begin bad++; $display("FAIL rst_thr got=%0d want=64", thr_active); end
`ifdef EDGE_BINARIZE_STATS_EN
      total++; if (edge_count !== 22'd0 || frame_mean !== 8'd0) begin bad++; $display("FAIL rst_stats got=%0d/%0d want=0/0", edge_count, frame_mean); end
`endif
      clear_mon();
      fill(8'd40);
      send_frame(0, thr_a);
      drive_idle(4);
      total++; if (thr_a !== 8'd64) begin bad++; $display("FAIL f1_thr got=%0d want=64", thr_a); end
      total++; if (out_q.size() !== 32) begin bad++; $display("FAIL f1_count got=%0d want=32", out_q.size()); end
      else begin
         total++; if (count_on(0, 32) !== 0) begin bad++; $display("FAIL f1_edges got=%0d want=0", count_on(0, 32)); end
         total++; if (fd_q[31] !== 1'b1 || fd_q[30] !== 1'b0) begin bad++; $display("FAIL f1_fd got=%b%b want=01", fd_q[30], fd_q[31]); end
      end
      total++; if (thr_active !== 8'd64) begin bad++; $display("FAIL f1_thr_hold got=%0d want=64", thr_active); end
   endtask

   task automatic test_adaptive();
      clear_mon();
      fill(8'd40); fpx[9] = 8'd69; fpx[10] = 8'd68;
      send_frame(0, thr_a);
      drive_idle(4);
      total++; if (thr_a !== 8'd68) begin bad++; $display("FAIL ad_thr got=%0d want=68", thr_a); end
      total++; if (out_q.size() !== 32) begin bad++; $display("FAIL ad_count got=%0d want=32", out_q.size()); end
      else begin
         total++; if (out_q[9] !== ON) begin bad++; $display("FAIL ad_69 got=%h want=%h", out_q[9], ON); end
         total++; if (out_q[10] !== OFF) begin bad++; $display("FAIL ad_68 got=%h want=%h", out_q[10], OFF); end
         total++; if (count_on(0, 32) !== 1) begin bad++; $display("FAIL ad_edges got=%0d want=1", count_on(0, 32)); end
      end
      // 255 frame under threshold 69, then a back-to-back frame under 255.
      clear_mon();
      fill(8'd255);
      send_frame(0, thr_a);
      send_frame(0, thr_b);
      drive_idle(4);
      total++; if (thr_a !== 8'd69) begin bad++; $display("FAIL sat_thr_a got=%0d want=69", thr_a); end
      total++; if (thr_b !== 8'd255) begin bad++; $display("FAIL b2b_thr got=%0d want=255", thr_b); end
      total++; if (out_q.size() !== 64) begin bad++; $display("FAIL b2b_count got=%0d want=64", out_q.size()); end
      else begin
         total++; if (count_on(0, 32) !== 12) begin bad++; $display("FAIL sat_edges_a got=%0d want=12", count_on(0, 32)); end
         total++; if (count_on(32, 64) !== 0) begin bad++; $display("FAIL sat_edges_b got=%0d want=0", count_on(32, 64)); end
         total++; if (fd_q[31] !== 1'b1 || fd_q[63] !== 1'b1 || fd_q[32] !== 1'b0) begin bad++; $display("FAIL b2b_fd got=%b%b%b want=101", fd_q[31], fd_q[32], fd_q[63]); end
      end
`ifdef EDGE_BINARIZE_STATS_EN
      total++; if (edge_count !== 22'd0 || frame_mean !== 8'd255) begin bad++; $display("FAIL b2b_stats got=%0d/%0d want=0/255", edge_count, frame_mean); end
`endif
   endtask

   task automatic test_manual();
      clear_mon();
      manual_en = 1'b1; manual_thr = 8'd100;
      fill(8'd0); fpx[11] = 8'd101; fpx[12] = 8'd100; fpx[13] = 8'd50;
      for (int i = 0; i < 32; i++) begin
         if (i == 11 || i == 12) drive_idle(3);
         if (i == 13) manual_thr = 8'd0;
         drive_pix(fpx[i]);
         if (i == 11 || i == 12) begin
            @(negedge clk);
            src_valid = 1'b0;
            total++; if (dst_valid !== 1'b0) begin bad++; $display("FAIL lat_early_%0d got=%b want=0", i, dst_valid); end
            @(negedge clk);
            total++;
            if (dst_valid !== 1'b1 || dst_data !== ((i == 11) ? ON : OFF)) begin
               bad++; $display("FAIL lat2_%0d got=%b/%h want=1/%h", i, dst_valid, dst_data, (i == 11) ? ON : OFF);
            end
         end
      end
      drive_idle(4);
      total++; if (thr_active !== 8'd100) begin bad++; $display("FAIL man_thr got=%0d want=100", thr_active); end
      total++; if (out_q.size() !== 32) begin bad++; $display("FAIL man_count got=%0d want=32", out_q.size()); end
      else begin
         total++; if (out_q[13] !== OFF || count_on(0, 32) !== 1) begin bad++; $display("FAIL man_midchg got=%h/%0d want=%h/1", out_q[13], count_on(0, 32), OFF); end
      end
   endtask

   task automatic test_border();
      clear_mon();
      manual_en = 1'b1; manual_thr = 8'd100;
      fill(8'd0);
      fpx[0] = 8'd255; fpx[23] = 8'd255; fpx[28] = 8'd255; fpx[8] = 8'd255; fpx[9] = 8'd255;
      send_frame(0, thr_a);
      drive_idle(4);
      total++; if (out_q.size() !== 32) begin bad++; $display("FAIL brd_count got=%0d want=32", out_q.size()); end
      else begin
         total++;
         if (out_q[0] !== OFF || out_q[23] !== OFF || out_q[28] !== OFF || out_q[8] !== OFF) begin
            bad++; $display("FAIL brd_zero got=%h %h %h %h want=0", out_q[0], out_q[23], out_q[28], out_q[8]);
         end
         total++; if (out_q[9] !== ON) begin bad++; $display("FAIL brd_inner got=%h want=%h", out_q[9], ON); end
         total++; if (count_on(0, 32) !== 1) begin bad++; $display("FAIL brd_edges got=%0d want=1", count_on(0, 32)); end
      end
   endtask

   task automatic test_gaps();
      int r, c, mism;
      logic [7:0] p;
      manual_en = 1'b1; manual_thr = 8'd128;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 32; i++) begin
            p = 8'((i * 37 + f * 11 + 5) % 256);
            r = i / 8; c = i % 8;
            exp_seq[f*32+i] = (r != 0 && r != 3 && c != 0 && c != 7 && p > 8'd128) ? ON : OFF;
         end
      end
      for (int run = 0; run < 2; run++) begin
         clear_mon();
         for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 32; i++) fpx[i] = 8'((i * 37 + f * 11 + 5) % 256);
            send_frame(run * 3, thr_a);
         end
         drive_idle(4);
         total++; if (out_q.size() !== 64) begin bad++; $display("FAIL gap%0d_count got=%0d want=64", run, out_q.size()); end
         else begin
            mism = 0;
            for (int i = 0; i < 64; i++) if (out_q[i] !== exp_seq[i]) mism++;
            total++; if (mism !== 0) begin bad++; $display("FAIL gap%0d_seq got=%0d_diffs want=0", run, mism); end
            mism = 0;
            for (int i = 0; i < 64; i++) if (fd_q[i] !== (i == 31 || i == 63)) mism++;
            total++; if (mism !== 0) begin bad++; $display("FAIL gap%0d_fd got=%0d_diffs want=0", run, mism); end
         end
      end
   endtask

   task automatic test_reset_mid();
      manual_en = 1'b0;
      for (int i = 0; i < 10; i++) drive_pix(8'd200);
      @(negedge clk);
      rst_n = 1'b0; src_valid = 1'b0; src_data = 24'h0;
      @(negedge clk);
      total++; if (thr_active !== 8'd64 || dst_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0d/%b want=64/0", thr_active, dst_valid); end
`ifdef EDGE_BINARIZE_STATS_EN
      total++; if (edge_count !== 22'd0 || frame_mean !== 8'd0) begin bad++; $display("FAIL mid_stats got=%0d/%0d want=0/0", edge_count, frame_mean); end
`endif
      rst_n = 1'b1;
      clear_mon();
      fill(8'd40); fpx[9] = 8'd65; fpx[10] = 8'd64;
      send_frame(0, thr_a);
      drive_idle(4);
      total++; if (thr_a !== 8'd64) begin bad++; $display("FAIL mid_thr got=%0d want=64", thr_a); end
      total++; if (out_q.size() !== 32) begin bad++; $display("FAIL mid_count got=%0d want=32", out_q.size()); end
      else begin
         total++; if (fd_q[31] !== 1'b1 || fd_q[30] !== 1'b0) begin bad++; $display("FAIL mid_fd got=%b%b want=01", fd_q[30], fd_q[31]); end
         total++; if (out_q[9] !== ON || out_q[10] !== OFF) begin bad++; $display("FAIL mid_px got=%h/%h want=%h/%h", out_q[9], out_q[10], ON, OFF); end
      end
      total++; if (thr_active !== 8'd64) begin bad++; $display("FAIL mid_thr_hold got=%0d want=64", thr_active); end
`ifdef EDGE_BINARIZE_STATS_EN
      total++; if (edge_count !== 22'd1 || frame_mean !== 8'd41) begin bad++; $display("FAIL mid_stats2 got=%0d/%0d want=1/41", edge_count, frame_mean); end
`endif
   endtask

   initial begin
      test_reset();
      test_adaptive();
      test_manual();
      test_border();
      test_gaps();
      test_reset_mid();
      total++; if (stray_fd !== 0) begin bad++; $display("FAIL stray_fd got=%0d want=0", stray_fd); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/edge_binarize.md
Name: edge_binarize

Overview:
Downstream stage of the Sobel edge detector. Consumes the 24-bit replicated gradient-magnitude stream and thresholds it to a binary edge map (0x000000 / 0xFFFFFF). Also zeroes the one-pixel frame border. The threshold is either a manual value or derived adaptively from the previous frame's mean gradient. Feeds display/frame-buffer write logic; there is no backpressure.

Parameters:
WIDTH, 1920, active pixels per line
HEIGHT, 1080, active lines per frame
CNT_W, 11, width of the column/row counters
SUM_W, 32, width of the frame-sum accumulator
MEAN_SHIFT, 21, right shift applied to the frame sum to approximate the mean (2^21 ≈ 1920*1080)
INIT_THR, 64, adaptive threshold used after reset, before the first frame completes
THR_OFFSET, 8, constant added to the adaptive threshold

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
src_valid  input  1  input pixel valid; no ready, always accepted
src_data  input  24  gradient magnitude; only [7:0] used
manual_en  input  1  1: use manual_thr; 0: adaptive threshold
manual_thr  input  8  manual threshold
dst_valid  output  1  output pixel valid
dst_data  output  24  0xFFFFFF = edge, 0x000000 = no edge
frame_done  output  1  one-cycle pulse with dst_valid of the last pixel of a frame
thr_active  output  8  threshold currently in force

Behaviour:
- Reset values: dst_valid=0, dst_data=0, frame_done=0, thr_active=INIT_THR. Internal state also clears: counters, sum, latched cfg, adaptive thr=INIT_THR.
- Counters cnt_w/cnt_h advance only on src_valid.
  - cnt_w wraps at WIDTH-1 and then increments cnt_h.
  - cnt_h wraps at HEIGHT-1 to 0.
  - Gaps in src_valid hold all state.
- Frame start = src_valid with cnt_w==0 and cnt_h==0. On this cycle, manual_en/manual_thr are latched and used for the whole frame; mid-frame changes are ignored.
- Effective threshold T = latched manual_thr if latched manual_en=1, else the adaptive register.
- Pixel decision:
  - edge = (pix > T), strict comparison.
  - Forced to 0 when cnt_h==0, cnt_h==HEIGHT-1, cnt_w==0 or cnt_w==WIDTH-1.
- Latency: fixed 2 cycles, src_valid -> dst_valid.
  - Stage 1 registers pix, border flag, last flag and T.
  - Stage 2 registers the output.
- Adaptive update:
  - sum accumulates pix on every valid pixel, regardless of mode.
  - On the last pixel (cnt_w==WIDTH-1 and cnt_h==HEIGHT-1): mean = (sum+pix)>>MEAN_SHIFT, saturated to 8 bits; thr_next = sat255(mean + (mean>>1) + THR_OFFSET).
  - The adaptive register loads thr_next on that same edge and sum clears to 0.
  - A back-to-back frame whose first pixel arrives on the next cycle uses the new threshold.
- thr_active reflects T: latched cfg/adaptive register, updated at frame start.
- frame_done asserts 2 cycles after the last pixel is accepted, aligned with its dst_valid.
- Reset mid-frame: all state clears; the next pixel is treated as (0,0), and that partial frame contributes nothing.
- Arithmetic: sum is unsigned SUM_W bits with no overflow at the defaults. Intermediate threshold math is 10 bits, then saturated.

Optional Feature:
EDGE_BINARIZE_STATS_EN
- Defined: adds output edge_count[21:0] (number of 0xFFFFFF pixels in the last completed frame) and output frame_mean[7:0] (mean used for the last adaptive update). Both update together with frame_done and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: counter/sum widths, EDGE_ON/EDGE_OFF 24-bit constants, sat8 function.
- One sub-module, edge_thr_calc:
  - Inputs: sum, pix, last, offset.
  - Output: saturated thr_next.
  - Purely combinational; the register stays in edge_binarize.
- The valid/last pipeline uses the team's existing delay block.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4, MEAN_SHIFT=5, INIT_THR=64, THR_OFFSET=8.
1. Reset, then idle -> dst_valid=0, dst_data=0, frame_done=0, thr_active=64; after the first full frame with manual_en=0, thr_active changes at the next frame start.
2. manual_en=1, manual_thr=100; interior pixel (3,1)=101 -> dst_data=0xFFFFFF exactly 2 cycles later; pixel 100 -> 0x000000.
3. Pixels of 255 at (0,0), (7,2), (4,3), (0,1) -> 0x000000; 255 at (1,1) -> 0xFFFFFF.
4. Adaptive mode:
   - Frame of all 40 -> next frame thr_active=68; interior 69 -> 0xFFFFFF, 68 -> 0x000000.
   - Frame of all 255 -> thr=255, nothing passes.
   - Second frame sent back-to-back with no gap -> its first pixel already uses the new threshold.
5. Random src_valid gaps across 2 frames -> output sequence identical to the gap-free run; exactly one frame_done per frame, coincident with the 32nd output.
6. Assert rst_n after 10 pixels, then send a full frame -> frame_done after 32 pixels; threshold reverts to 64 until that frame ends; with EDGE_BINARIZE_STATS_EN, edge_count and frame_mean are 0 after reset.
